seq_det_ctrl: RTL and testbench

Programmable serial-pattern detection controller for the sequence-detector datapath.
- Accepts a configured pattern of 1..MAX_LEN bits and arms on `start`.
- Consumes a valid/ready serial bit stream and reports each match through a valid/ready event port.
- Counts matches and terminates on a match limit, a bit-window limit, or abort.
- Sits between the bus-side configuration registers and the serial input front end.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_det_if.sv | 14 +
 rtl/seq_det_matcher.sv | 38 +++
 rtl/seq_det_ctrl.sv | 95 +++++++++
 tb/tb_seq_det_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and FSM state encoding for the sequence detector
package seq_det_pkg;
    localparam int SD_MAX_LEN = 8;
    localparam int SD_CNT_W = 16;
    localparam int SD_LEN_W = $clog2(SD_MAX_LEN + 1);
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN = 2'd1;
    localparam state_t REPORT = 2'd2;
    localparam state_t DONE = 2'd3;
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial bit stream and match event handshakes
// bit_valid/bit_in/bit_ready: serial input; evt_valid/evt_ready/evt_pos: match events
interface seq_det_if import seq_det_pkg::*; #(
    parameter int CNT_W = SD_CNT_W
);
    logic bit_valid;
    logic bit_in;
    logic bit_ready;
    logic evt_valid;
    logic evt_ready;
    logic [CNT_W-1:0] evt_pos;
    modport master(output bit_valid, bit_in, evt_ready, input bit_ready, evt_valid, evt_pos);
    modport slave(input bit_valid, bit_in, evt_ready, output bit_ready, evt_valid, evt_pos);
endinterface

// File: rtl/seq_det_matcher.sv
// seq_det_matcher: history shift register, fill counter and masked pattern compare
// clr restarts the history; shift accepts bit_in; match flags the post-shift compare
module seq_det_matcher import seq_det_pkg::*; #(
    parameter int MAX_LEN = SD_MAX_LEN,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);
    logic [MAX_LEN-1:0] history, hist_n, mask;
    logic [LEN_W-1:0] fill, fill_n;
    // match is evaluated on the values the shift is about to store
    always_comb begin
        hist_n = {history[MAX_LEN-2:0], bit_in};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        mask = ~({MAX_LEN{1'b1}} << len);
        match = shift && (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= '0;
            fill <= '0;
        end else if (clr) begin
            history <= '0;
            fill <= '0;
        end else if (shift) begin
            history <= hist_n;
            fill <= (match && !overlap) ? '0 : fill_n;
        end
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with match events and limits
// start/abort/cfg_*: control and configuration; bus: bit stream and event port
// match_count/busy/done/cfg_err: status
module seq_det_ctrl import seq_det_pkg::*; #(
    parameter int MAX_LEN = SD_MAX_LEN,
    parameter int CNT_W = SD_CNT_W,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_max_matches,
    input  logic [CNT_W-1:0]   cfg_window,
    seq_det_if.slave           bus,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    state_t state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic ovl_q, len_ok, arm, shift, match;
    logic [CNT_W-1:0] max_q, win_q, bit_count, bc_n, mc_n;
    always_comb begin
        len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        arm = (state == IDLE) && start && !abort && len_ok;
        shift = (state == RUN) && bus.bit_valid && !abort;
        bc_n = (&bit_count) ? bit_count : bit_count + 1'b1;
        mc_n = (&match_count) ? match_count : match_count + 1'b1;
        bus.bit_ready = state == RUN;
        busy = state != IDLE;
        done = state == DONE;
    end
    seq_det_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
        .clk(clk),
        .rst(rst),
        .clr(arm),
        .shift(shift),
        .bit_in(bus.bit_in),
        .pattern(pat_q),
        .len(len_q),
        .overlap(ovl_q),
        .match(match)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
            max_q <= '0;
            win_q <= '0;
            bit_count <= '0;
            match_count <= '0;
            bus.evt_valid <= 1'b0;
            bus.evt_pos <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start && !abort && !len_ok;
            if (abort && state != IDLE) begin
                state <= IDLE;
                bus.evt_valid <= 1'b0;
            end else if (arm) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                max_q <= cfg_max_matches;
                win_q <= cfg_window;
                bit_count <= '0;
                match_count <= '0;
                state <= RUN;
            end else if (shift) begin
                bit_count <= bc_n;
                if (match) begin
                    bus.evt_valid <= 1'b1;
                    bus.evt_pos <= bit_count;
                    state <= REPORT;
                end else if (win_q != '0 && bc_n >= win_q) begin
                    state <= DONE;
                end
            end else if (state == REPORT && bus.evt_ready) begin
                bus.evt_valid <= 1'b0;
                match_count <= mc_n;
                state <= ((max_q != '0 && mc_n >= max_q) || (win_q != '0 && bit_count >= win_q)) ? DONE : RUN;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed and randomized bench for seq_det_ctrl with a reference model
module tb_seq_det_ctrl;
    import seq_det_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic cfg_overlap = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic [15:0] cfg_max_matches = '0;
    logic [15:0] cfg_window = '0;
    logic [15:0] match_count;
    logic busy, done, cfg_err;
    int n_checks = 0;
    int n_fail = 0;
    bit stim[64];
    int got_pos[$];
    int exp_pos[$];
    int got_acc, got_done, got_viol, exp_acc, exp_done;

    seq_det_if #(.CNT_W(16)) bus();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_max_matches(cfg_max_matches),
        .cfg_window(cfg_window),
        .bus(bus),
        .match_count(match_count),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string qs(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d,", q[i])};
        return s;
    endfunction

    task automatic load(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) stim[i] = v[n-1-i];
    endtask

    task automatic arm(input logic [7:0] p, input int l, input bit o, input int mx, input int w);
        cfg_pattern = p;
        cfg_len = 4'(l);
        cfg_overlap = o;
        cfg_max_matches = 16'(mx);
        cfg_window = 16'(w);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Reference: a match ends at bit i when at least len bits have arrived since
    // arming (or since the previous match in non-overlap mode) and the last len
    // bits equal the pattern, read first-received-first from bit[len-1].
    task automatic model(input int n);
        int since = 0;
        bit hit;
        exp_pos.delete();
        exp_acc = 0;
        exp_done = 0;
        for (int i = 0; i < n && exp_done == 0; i++) begin
            exp_acc = i + 1;
            since++;
            hit = since >= int'(cfg_len);
            for (int j = 0; j < int'(cfg_len); j++) if (hit && stim[i-j] != cfg_pattern[j]) hit = 0;
            if (hit) begin
                exp_pos.push_back(i);
                if (!cfg_overlap) since = 0;
            end
            if ((hit && cfg_max_matches != 0 && exp_pos.size() >= int'(cfg_max_matches)) ||
                (cfg_window != 0 && i + 1 >= int'(cfg_window))) exp_done = 1;
        end
    endtask

    // Feeds stim[k0..n-1] with random gaps and random evt_ready; records events,
    // accepted bits, done pulses and handshake-rule violations.
    task automatic run_stream(input int k0, input int n, input int rdy_pct);
        int k = k0;
        bit held = 0;
        logic [15:0] held_pos = '0;
        got_pos.delete();
        got_done = 0;
        got_viol = 0;
        for (int c = 0; c < 10 * n + 60; c++) begin
            if (done) got_done++;
            if (bus.evt_valid && bus.bit_ready) got_viol++;
            if (bus.evt_valid && held && bus.evt_pos !== held_pos) got_viol++;
            bus.bit_valid = (k < n) && ($urandom_range(0, 3) != 0);
            bus.bit_in = bus.bit_valid ? stim[k] : 1'($urandom);
            bus.evt_ready = $urandom_range(0, 99) < rdy_pct;
            if (bus.bit_valid && bus.bit_ready) k++;
            if (bus.evt_valid && bus.evt_ready) got_pos.push_back(int'(bus.evt_pos));
            held = bus.evt_valid && !bus.evt_ready;
            held_pos = bus.evt_pos;
            tick();
        end
        bus.bit_valid = 1'b0;
        bus.evt_ready = 1'b0;
        got_acc = k;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if ({busy, done, cfg_err, bus.evt_valid, bus.bit_ready, match_count, bus.evt_pos} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, cfg_err, bus.evt_valid, bus.bit_ready, match_count, bus.evt_pos}); end
        rst = 1'b0;
        tick();
        n_checks++; if ({busy, done, bus.evt_valid, match_count} !== '0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", {busy, done, bus.evt_valid, match_count}); end
    endtask

    task automatic test_overlap();
        load(32'b01010101, 8);
        arm(8'b0101, 4, 1, 0, 0);
        run_stream(0, 8, 100);
        n_checks++; if (qs(got_pos) != "3,5,7,") begin n_fail++; $display("FAIL ovl_pos: got %s expected 3,5,7,", qs(got_pos)); end
        n_checks++; if (match_count !== 16'd3) begin n_fail++; $display("FAIL ovl_count: got %0d expected 3", match_count); end
        n_checks++; if (got_done !== 0) begin n_fail++; $display("FAIL ovl_done: got %0d expected 0", got_done); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovl_busy: got %b expected 1", busy); end
        do_abort();
    endtask

    task automatic test_nonoverlap_abort();
        load(32'b01010101, 8);
        arm(8'b0101, 4, 0, 0, 0);
        run_stream(0, 8, 100);
        n_checks++; if (qs(got_pos) != "3,7,") begin n_fail++; $display("FAIL novl_pos: got %s expected 3,7,", qs(got_pos)); end
        n_checks++; if (match_count !== 16'd2) begin n_fail++; $display("FAIL novl_count: got %0d expected 2", match_count); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (match_count !== 16'd2) begin n_fail++; $display("FAIL abort_count: got %0d expected 2", match_count); end
        got_done = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) got_done++;
            tick();
        end
        n_checks++; if (got_done !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", got_done); end
    endtask

    task automatic test_back_pressure();
        int acc = 0;
        int bad = 0;
        load(32'b111111, 6);
        arm(8'b111, 3, 1, 0, 0);
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        bus.evt_ready = 1'b0;
        for (int c = 0; c < 10 && !bus.evt_valid; c++) begin
            if (bus.bit_ready) acc++;
            tick();
        end
        bus.bit_valid = 1'b0;
        n_checks++; if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_event: got %b expected 1 within 10 cycles", bus.evt_valid); end
        n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 3", acc); end
        for (int c = 0; c < 5; c++) begin
            if (bus.evt_valid !== 1'b1 || bus.evt_pos !== 16'd2 || bus.bit_ready !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        run_stream(3, 6, 100);
        n_checks++; if (qs(got_pos) != "2,3,4,5,") begin n_fail++; $display("FAIL bp_pos: got %s expected 2,3,4,5,", qs(got_pos)); end
        n_checks++; if (got_acc !== 6) begin n_fail++; $display("FAIL bp_total: got %0d expected 6", got_acc); end
        n_checks++; if (match_count !== 16'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", match_count); end
        do_abort();
    endtask

    task automatic test_limits();
        load(32'b10101101, 8);
        arm(8'b101, 3, 1, 1, 0);
        run_stream(0, 8, 100);
        n_checks++; if (qs(got_pos) != "2,") begin n_fail++; $display("FAIL max_pos: got %s expected 2,", qs(got_pos)); end
        n_checks++; if (got_acc !== 3) begin n_fail++; $display("FAIL max_accepted: got %0d expected 3", got_acc); end
        n_checks++; if (got_done !== 1) begin n_fail++; $display("FAIL max_done: got %0d expected 1", got_done); end
        n_checks++; if (match_count !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL max_end: got count %0d busy %b expected 1 0", match_count, busy); end
        load(32'b011010111, 9);
        arm(8'b1111, 4, 1, 0, 6);
        run_stream(0, 9, 100);
        n_checks++; if (got_acc !== 6) begin n_fail++; $display("FAIL win_accepted: got %0d expected 6", got_acc); end
        n_checks++; if (got_done !== 1) begin n_fail++; $display("FAIL win_done: got %0d expected 1", got_done); end
        n_checks++; if (match_count !== 16'd0 || got_pos.size() !== 0) begin n_fail++; $display("FAIL win_matches: got count %0d events %0d expected 0 0", match_count, got_pos.size()); end
    endtask

    task automatic test_cfg_reject();
        for (int t = 0; t < 2; t++) begin
            cfg_len = (t == 0) ? 4'd0 : 4'd9;
            start = 1'b1;
            tick();
            start = 1'b0;
            n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reject_len%0d: got cfg_err %b busy %b expected 1 0", cfg_len, cfg_err, busy); end
            tick();
            n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reject_pulse%0d: got %b expected 0", cfg_len, cfg_err); end
        end
        cfg_len = 4'd4;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL start_abort: got busy %b cfg_err %b expected 0 0", busy, cfg_err); end
    endtask

    task automatic test_reset_mid();
        load(32'b1111, 4);
        arm(8'b111, 3, 1, 0, 0);
        run_stream(0, 4, 100);
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_pos !== 16'd4 || match_count !== 16'd2) begin n_fail++; $display("FAIL pre_reset: got valid %b pos %0d count %0d expected 1 4 2", bus.evt_valid, bus.evt_pos, match_count); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.evt_valid !== 1'b0 || busy !== 1'b0 || match_count !== 16'd0) begin n_fail++; $display("FAIL async_reset: got valid %b busy %b count %0d expected 0 0 0", bus.evt_valid, busy, match_count); end
        #2 rst = 1'b0;
        tick();
        load(32'b0101, 4);
        arm(8'b0101, 4, 0, 0, 0);
        run_stream(0, 4, 100);
        n_checks++; if (qs(got_pos) != "3," || match_count !== 16'd1) begin n_fail++; $display("FAIL rearm: got %s count %0d expected 3, count 1", qs(got_pos), match_count); end
        do_abort();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int l = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 8) : $urandom_range(1, 3);
            int n = $urandom_range(4, 24);
            for (int i = 0; i < n; i++) stim[i] = 1'($urandom_range(0, 1));
            arm(8'($urandom), l, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 1) ? $urandom_range(3, 24) : 0);
            model(n);
            run_stream(0, n, $urandom_range(40, 100));
            n_checks++; if (qs(got_pos) != qs(exp_pos)) begin n_fail++; $display("FAIL rnd%0d_pos: got %s expected %s", it, qs(got_pos), qs(exp_pos)); end
            n_checks++; if (int'(match_count) !== exp_pos.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, match_count, exp_pos.size()); end
            n_checks++; if (got_done !== exp_done) begin n_fail++; $display("FAIL rnd%0d_done: got %0d expected %0d", it, got_done, exp_done); end
            n_checks++; if (got_acc !== exp_acc) begin n_fail++; $display("FAIL rnd%0d_accepted: got %0d expected %0d", it, got_acc, exp_acc); end
            n_checks++; if (got_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_handshake: got %0d violations expected 0", it, got_viol); end
            n_checks++; if (busy !== !exp_done) begin n_fail++; $display("FAIL rnd%0d_busy: got %b expected %b", it, busy, !exp_done); end
            if (busy) do_abort();
        end
    endtask

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        bus.evt_ready = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap_abort();
        test_back_pressure();
        test_limits();
        test_cfg_reject();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
